// File: rtl/window_instr_issuer.sv
// Raster pixel-pair stream to 3x3 window instruction issuer.
// Two line buffers and a 3x3 shift window per image feed a single output register.
package window_instr_pkg;
  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    ADDI = 2'd2,
    SUBI = 2'd3
  } opcodes_t;
endpackage

module window_instr_issuer
  import window_instr_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int PIXEL_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_W-1:0]     in_pixel_a,
  input  logic [PIXEL_W-1:0]     in_pixel_b,
  input  opcodes_t               cfg_opcode,
  input  logic [PIXEL_W-1:0]     cfg_user_input,
  output logic                   out_valid,
  input  logic                   out_ready,
  output opcodes_t               out_opcode,
  output logic [9*PIXEL_W-1:0]   out_cell_a,
  output logic [9*PIXEL_W-1:0]   out_cell_b,
  output logic [PIXEL_W-1:0]     out_user_input,
  output logic                   frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;
  opcodes_t             r_frame_op;
  logic [PIXEL_W-1:0]   r_frame_user;

  logic                 r_out_valid;
  opcodes_t             r_out_op;
  logic [9*PIXEL_W-1:0] r_out_cell_a;
  logic [9*PIXEL_W-1:0] r_out_cell_b;
  logic [PIXEL_W-1:0]   r_out_user;
  logic                 r_frame_done;

  logic [PIXEL_W-1:0]   r_lb1_a [IMG_WIDTH];
  logic [PIXEL_W-1:0]   r_lb2_a [IMG_WIDTH];
  logic [PIXEL_W-1:0]   r_lb1_b [IMG_WIDTH];
  logic [PIXEL_W-1:0]   r_lb2_b [IMG_WIDTH];

  // Two older window columns per line: index 0 is col-2, index 1 is col-1.
  logic [PIXEL_W-1:0]   r_win_a [3][2];
  logic [PIXEL_W-1:0]   r_win_b [3][2];

  logic                 w_accept;
  logic                 w_complete;
  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_first_pix;
  logic [PIXEL_W-1:0]   w_newcol_a [3];
  logic [PIXEL_W-1:0]   w_newcol_b [3];
  logic [9*PIXEL_W-1:0] w_cell_a;
  logic [9*PIXEL_W-1:0] w_cell_b;

  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_col_last  = (r_col == COL_LAST);
  assign w_row_last  = (r_row == ROW_LAST);
  assign w_first_pix = (r_col == '0) && (r_row == '0);
  assign w_complete  = (r_row >= RW'(2)) && (r_col >= CW'(2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_op   <= ADD;
      r_frame_user <= '0;
    end else if (w_accept && w_first_pix) begin
      r_frame_op   <= cfg_opcode;
      r_frame_user <= cfg_user_input;
    end
  end

  // Line buffers shift down one line per column slot; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1_a[r_col] <= in_pixel_a;
      r_lb2_a[r_col] <= r_lb1_a[r_col];
      r_lb1_b[r_col] <= in_pixel_b;
      r_lb2_b[r_col] <= r_lb1_b[r_col];
    end
  end

  always_comb begin
    w_newcol_a[0] = r_lb2_a[r_col];
    w_newcol_a[1] = r_lb1_a[r_col];
    w_newcol_a[2] = in_pixel_a;
    w_newcol_b[0] = r_lb2_b[r_col];
    w_newcol_b[1] = r_lb1_b[r_col];
    w_newcol_b[2] = in_pixel_b;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int r = 0; r < 3; r++) begin
        r_win_a[r][0] <= r_win_a[r][1];
        r_win_a[r][1] <= w_newcol_a[r];
        r_win_b[r][0] <= r_win_b[r][1];
        r_win_b[r][1] <= w_newcol_b[r];
      end
    end
  end

  always_comb begin
    w_cell_a = '0;
    w_cell_b = '0;
    for (int r = 0; r < 3; r++) begin
      w_cell_a[(r*3+0)*PIXEL_W +: PIXEL_W] = r_win_a[r][0];
      w_cell_a[(r*3+1)*PIXEL_W +: PIXEL_W] = r_win_a[r][1];
      w_cell_a[(r*3+2)*PIXEL_W +: PIXEL_W] = w_newcol_a[r];
      w_cell_b[(r*3+0)*PIXEL_W +: PIXEL_W] = r_win_b[r][0];
      w_cell_b[(r*3+1)*PIXEL_W +: PIXEL_W] = r_win_b[r][1];
      w_cell_b[(r*3+2)*PIXEL_W +: PIXEL_W] = w_newcol_b[r];
    end
  end

  // A completing pixel overwrites the held word even when it is consumed the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_out_op     <= ADD;
      r_out_cell_a <= '0;
      r_out_cell_b <= '0;
      r_out_user   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept && w_col_last && w_row_last;
      if (w_accept && w_complete) begin
        r_out_valid  <= 1'b1;
        r_out_op     <= r_frame_op;
        r_out_cell_a <= w_cell_a;
        r_out_cell_b <= w_cell_b;
        r_out_user   <= r_frame_user;
      end else if (out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_opcode     = r_out_op;
  assign out_cell_a     = r_out_cell_a;
  assign out_cell_b     = r_out_cell_b;
  assign out_user_input = r_out_user;
  assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_window_instr_issuer.sv
// Scoreboard bench for window_instr_issuer on a 5x4 frame with pixel A = row*16+col.
module tb_window_instr_issuer;
  import window_instr_pkg::*;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int PW = 8;
  localparam logic [71:0] FIRST_A = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [71:0] LAST_A  = 72'h34_33_32_24_23_22_14_13_12;

  typedef struct {
    opcodes_t    op;
    logic [7:0]  u;
    logic [71:0] a;
    logic [71:0] b;
  } word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_pixel_a;
  logic [PW-1:0] in_pixel_b;
  opcodes_t      cfg_opcode;
  logic [PW-1:0] cfg_user_input;
  logic          out_valid;
  logic          out_ready = 1'b1;
  opcodes_t      out_opcode;
  logic [71:0]   out_cell_a;
  logic [71:0]   out_cell_b;
  logic [PW-1:0] out_user_input;
  logic          frame_done;

  int    total = 0;
  int    bad = 0;
  word_t exp_q[$];
  int    n_out = 0;
  int    fd_cnt = 0;
  int    stall_cyc = 0;
  int    rdy_mode = 0;

  window_instr_issuer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_W(PW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel_a(in_pixel_a), .in_pixel_b(in_pixel_b),
    .cfg_opcode(cfg_opcode), .cfg_user_input(cfg_user_input),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_cell_a(out_cell_a), .out_cell_b(out_cell_b),
    .out_user_input(out_user_input), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix_a(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  function automatic logic [7:0] pix_b(input logic [7:0] a, input int bsel);
    case (bsel)
      0:       return 8'hFF - a;
      1:       return a ^ 8'h5A;
      default: return 8'hAA;
    endcase
  endfunction

  function automatic word_t mk_word(input int row, input int col, input opcodes_t op,
                                    input logic [7:0] u, input int bsel);
    word_t w;
    logic [7:0] a;
    w.op = op;
    w.u  = u;
    w.a  = '0;
    w.b  = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        a = pix_a(row - 2 + r, col - 2 + c);
        w.a[(r*3+c)*8 +: 8] = a;
        w.b[(r*3+c)*8 +: 8] = pix_b(a, bsel);
      end
    return w;
  endfunction

  // Ready driver: 0 = always ready, 1 = random, 2 = five-cycle stall on first valid.
  always @(posedge clk) begin : rdy_drv
    int prev_mode;
    bit armed;
    int left;
    #1;
    if (rdy_mode == 2 && prev_mode != 2) begin
      armed = 1'b1;
      left  = 0;
    end
    prev_mode = rdy_mode;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (armed && out_valid) begin
          armed = 1'b0;
          left  = 5;
        end
        if (left > 0) begin
          out_ready = 1'b0;
          left--;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  end

  always @(negedge clk) begin : monitor
    word_t e;
    bit was_stalled;
    logic [71:0] held;
    if (rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 72'(out_valid), 72'(0));
        end else begin
          e = exp_q.pop_front();
          check("opcode", 72'(out_opcode), 72'(e.op));
          check("user_input", 72'(out_user_input), 72'(e.u));
          check("cell_a", out_cell_a, e.a);
          check("cell_b", out_cell_b, e.b);
        end
        n_out++;
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 72'(in_ready), 72'(0));
        if (was_stalled) check("stall_hold_cell_a", out_cell_a, held);
        held = out_cell_a;
        was_stalled = 1'b1;
        stall_cyc++;
      end else begin
        was_stalled = 1'b0;
      end
      if (frame_done) begin
        check("frame_done_valid", 72'(out_valid), 72'(1));
        check("frame_done_last_window", out_cell_a, LAST_A);
        fd_cnt++;
      end
    end
  end

  task automatic send_frame(input opcodes_t op0, input logic [7:0] u0, input opcodes_t opm,
                            input logic [7:0] um, input int bsel, input bit gaps,
                            input int npix, input bit chk_lat);
    int r, c, waitc;
    bit acc, lat_pend;
    lat_pend = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < npix; i++) begin
      r = i / W;
      c = i % W;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid       = 1'b1;
      in_pixel_a     = pix_a(r, c);
      in_pixel_b     = pix_b(pix_a(r, c), bsel);
      cfg_opcode     = (i < 7) ? op0 : opm;
      cfg_user_input = (i < 7) ? u0 : um;
      acc   = 1'b0;
      waitc = 0;
      while (!acc) begin
        @(negedge clk);
        if (lat_pend) begin
          check("latency_out_valid", 72'(out_valid), 72'(1));
          check("first_cell_a", out_cell_a, FIRST_A);
          check("first_cell_b", out_cell_b, ~FIRST_A);
          lat_pend = 1'b0;
        end
        acc = in_ready;
        if (acc && r >= 2 && c >= 2) exp_q.push_back(mk_word(r, c, op0, u0, bsel));
        if (acc && chk_lat && r == 2 && c == 2) begin
          check("no_valid_before_first", 72'(out_valid), 72'(0));
          lat_pend = 1'b1;
        end
        @(posedge clk); #1;
        if (!acc) begin
          waitc++;
          if (waitc > 200) begin
            check("in_ready_timeout", 72'(in_ready), 72'(1));
            acc = 1'b1;
          end
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 72'(exp_q.size()), 72'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 72'(out_valid), 72'(0));
    check({tag, "_in_ready"}, 72'(in_ready), 72'(1));
    check({tag, "_frame_done"}, 72'(frame_done), 72'(0));
    check({tag, "_opcode"}, 72'(out_opcode), 72'(0));
    check({tag, "_cell_a"}, out_cell_a, 72'(0));
    check({tag, "_cell_b"}, out_cell_b, 72'(0));
    check({tag, "_user"}, 72'(out_user_input), 72'(0));
  endtask

  initial begin
    int n0, f0, s0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_pixel_a = '0;
    in_pixel_b = '0;
    cfg_opcode = ADD;
    cfg_user_input = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // Streaming without backpressure
    n0 = n_out; f0 = fd_cnt;
    send_frame(ADD, 8'h00, ADD, 8'h00, 0, 1'b0, W * H, 1'b1);
    drain();
    check("stream_count", 72'(n_out - n0), 72'(6));
    check("stream_frame_done", 72'(fd_cnt - f0), 72'(1));

    // Backpressure on the first word
    rdy_mode = 2;
    n0 = n_out; f0 = fd_cnt; s0 = stall_cyc;
    send_frame(ADD, 8'h00, ADD, 8'h00, 1, 1'b0, W * H, 1'b0);
    drain();
    check("bp_count", 72'(n_out - n0), 72'(6));
    check("bp_stall_cycles", 72'(stall_cyc - s0), 72'(5));
    rdy_mode = 0;

    // Configuration latching across two frames
    n0 = n_out;
    send_frame(ADDI, 8'h20, SUB, 8'h55, 0, 1'b0, W * H, 1'b0);
    send_frame(SUBI, 8'h07, ADD, 8'h99, 1, 1'b0, W * H, 1'b0);
    drain();
    check("cfg_count", 72'(n_out - n0), 72'(12));

    // Random gaps and ready toggling over three back-to-back frames
    rdy_mode = 1;
    n0 = n_out; f0 = fd_cnt;
    send_frame(SUB, 8'h11, ADDI, 8'h22, 1, 1'b1, W * H, 1'b0);
    send_frame(ADDI, 8'h33, SUBI, 8'h44, 0, 1'b1, W * H, 1'b0);
    send_frame(SUBI, 8'h66, ADD, 8'h77, 1, 1'b1, W * H, 1'b0);
    drain();
    check("rand_count", 72'(n_out - n0), 72'(18));
    check("rand_frame_done", 72'(fd_cnt - f0), 72'(3));
    rdy_mode = 0;

    // Reset after nine pixels of a partial frame
    send_frame(SUB, 8'h55, SUB, 8'h55, 2, 1'b0, 9, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    n0 = n_out; f0 = fd_cnt;
    send_frame(ADD, 8'h00, ADD, 8'h00, 0, 1'b0, W * H, 1'b0);
    drain();
    check("after_reset_count", 72'(n_out - n0), 72'(6));
    check("after_reset_frame_done", 72'(fd_cnt - f0), 72'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_instr_issuer.md
# window_instr_issuer

Stream-to-instruction front end for the image processor. Accepts a raster pixel stream carrying lock-stepped A and B pixels, holds two previous lines of each in line buffers, and forms 3x3 neighbourhoods for every interior pixel. Each neighbourhood pair, together with the frame's opcode and user input, is issued as one instruction word to the processing core over a valid/ready handshake. This block is the initiator side of the instruction interface.

## Interface

- IMG_WIDTH, 8, pixels per line (>= 3)
- IMG_HEIGHT, 8, lines per frame (>= 3)
- PIXEL_W, 8, bits per pixel
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel pair present
- in_ready  out  1  pixel pair accepted when in_valid & in_ready
- in_pixel_a  in  PIXEL_W  image A pixel, raster order
- in_pixel_b  in  PIXEL_W  image B pixel, same coordinate as A
- cfg_opcode  in  opcodes_t  operation for the frame
- cfg_user_input  in  PIXEL_W  immediate operand for ADDI/SUBI
- out_valid  out  1  instruction word valid
- out_ready  in  1  core accepts instruction
- out_opcode  out  opcodes_t  latched frame opcode
- out_cell_a  out  9*PIXEL_W  A window; element (r,c) at bits [(r*3+c)*PIXEL_W +: PIXEL_W], r/c 0 = top/left
- out_cell_b  out  9*PIXEL_W  B window, same packing
- out_user_input  out  PIXEL_W  latched frame user input
- frame_done  out  1  one-cycle pulse, last pixel of frame accepted

## Operation

- Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) track the coordinate of the next accepted pixel. Col wraps to 0 and row increments at end of line. At frame end, both wrap to 0.
- cfg_opcode and cfg_user_input are sampled into frame registers when the pixel at (0,0) is accepted. They are held for the whole frame. Changes mid-frame are ignored.
- Two line buffers per image, each IMG_WIDTH deep, hold lines row-1 and row-2. A 3x3 shift window per image holds the last 3 columns of the 3 lines.
- Accepting the pixel at (row,col) with row >= 2 and col >= 2 completes the window centred at (row-1,col-1). That window is loaded into the output register and out_valid is set.
- No window is emitted for border centres. The frame therefore produces (IMG_WIDTH-2)*(IMG_HEIGHT-2) instructions.
- Window columns must never mix pixels from different lines. Windows are emitted only for col >= 2, so the column pipeline refills at each new line.
- in_ready = !out_valid | out_ready. There is a single output register and no skid buffer.
- Output hold: while out_valid & !out_ready, all out_* signals stay stable and no pixel is accepted.
- Accepted pixels that do not complete a window (row < 2 or col < 2) still update the buffers. out_valid drops if the held word was consumed that cycle.
- frame_done asserts the cycle after the pixel at (IMG_HEIGHT-1,IMG_WIDTH-1) is accepted.

## Timing

- Reset (rst low, asynchronous):
  - out_valid = 0, in_ready = 1, frame_done = 0.
  - out_opcode, out_cell_a, out_cell_b and out_user_input = 0.
  - row = col = 0; frame registers = 0.
  - Line buffer contents are not reset.
- Reset mid-frame abandons the partial frame. The next accepted pixel is (0,0).
- Latency: the completing pixel is accepted in cycle N, and out_valid with its window is presented in cycle N+1.
- Throughput: one pixel and one instruction per cycle when out_ready is held high.
- Simultaneous handshakes: if out_valid & out_ready and the accepted pixel completes a new window, the new word replaces the old one in the same cycle and out_valid stays 1.
- Frame boundary: the last window and frame_done appear in the same cycle. The (0,0) pixel of the next frame may be accepted back-to-back.

## Test plan

All scenarios use IMG_WIDTH=5, IMG_HEIGHT=4 and pixel A = row*16+col.

- **Streaming, no backpressure:** pixel B = 0xFF-A, opcode ADD, out_ready=1.
  - Exactly 6 instructions.
  - The first follows acceptance of pixel 13, (2,2), by 1 cycle.
  - Its out_cell_a rows are {00,01,02},{10,11,12},{20,21,22} and its out_cell_b is the complement.
  - The last window is centred at (2,3), and frame_done pulses together with it.
- **Backpressure:** hold out_ready=0 for 5 cycles after the first out_valid.
  - in_ready=0 and out_cell_a stays stable through the stall.
  - After release, all 6 windows are delivered in order, with none lost or duplicated.
- **Config latching:**
  - Set cfg_opcode=ADDI and cfg_user_input=0x20 at (0,0), then change them to SUB/0x55 mid-frame. All 6 words carry ADDI/0x20.
  - For the next frame, start with SUBI/0x07. All words carry SUBI/0x07.
- **Random in_valid gaps and out_ready toggling:** window contents match a reference model, and the count is 6 per frame over 3 back-to-back frames.
- **Mid-frame reset:** assert rst low after 9 pixels.
  - All outputs go to 0 and out_valid=0.
  - A fresh full frame then yields 6 correct windows with no stale pixels.
